// File: rtl/wb_trap_stage.sv
// wb_trap_stage
//   Writeback stage with trap entry. It registers register-file and CSR
//   write data for each retiring instruction class. It prioritises
//   interrupts over synchronous exceptions. On a trap it writes mepc,
//   mcause and optionally mtval through the single CSR write port, one
//   per cycle, and then redirects fetch to the trap vector.
//
//   Optional feature: define WB_TVAL_EN to add the mtval (0x343) write
//   after mcause. When it is undefined, the trap sequence is
//   EPC -> CAUSE -> REDIR.
//
//   Ports
//     CLK, RESET_N              clock, asynchronous active-low reset
//     WB_V .. WB_PC_MUX         WB instruction and its operands
//     WB_ECALL .. MEM_SAF       exception flags of the WB instruction
//     TIMER, EXTERNAL, IRQ_EN   level interrupt requests, global enable
//     PRIVILEGE, MTVEC          current mode (1 = M), trap vector CSR
//     WB_RF_DATA/LD_REG/DRID_OUT          register file write
//     WB_CSR_DATA/CSR_ADDR/ST_CSR         CSR write port
//     WB_BR_JMP_TARGET/WB_PC_MUX_OUT      fetch redirect
//     WB_FLUSH, WB_STALL, WB_CS           trap sequence in progress
//     WB_CAUSE                            cause of the most recent trap
//
//   state  | meaning
//   IDLE   | normal writeback; detects traps on a valid instruction
//   EPC    | presenting the mepc write (0x341 <= trapping PC)
//   CAUSE  | presenting the mcause write (0x342 <= cause)
//   TVAL   | presenting the mtval write (0x343 <= tval); WB_TVAL_EN only
//   REDIR  | presenting the fetch redirect to the trap vector
module wb_trap_stage #(
  parameter int XLEN     = 64,
  parameter int CSR_AW   = 12,
  parameter bit VECTORED = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WB_V,
  input  logic [XLEN-1:0]   WB_PC,
  input  logic [XLEN-1:0]   WB_NPC,
  input  logic [31:0]       WB_IR,
  input  logic [XLEN-1:0]   WB_MEM_RESULT,
  input  logic [XLEN-1:0]   WB_ALU_RESULT,
  input  logic [XLEN-1:0]   WB_RFD,
  input  logic [XLEN-1:0]   WB_CSRFD,
  input  logic [4:0]        WB_DRID,
  input  logic              WB_PC_MUX,
  input  logic              WB_ECALL,
  input  logic              F_IAM,
  input  logic              F_IAF,
  input  logic              F_II,
  input  logic              MEM_LAM,
  input  logic              MEM_LAF,
  input  logic              MEM_SAM,
  input  logic              MEM_SAF,
  input  logic              TIMER,
  input  logic              EXTERNAL,
  input  logic              IRQ_EN,
  input  logic              PRIVILEGE,
  input  logic [XLEN-1:0]   MTVEC,
  output logic [XLEN-1:0]   WB_RF_DATA,
  output logic              WB_LD_REG,
  output logic [4:0]        WB_DRID_OUT,
  output logic [XLEN-1:0]   WB_CSR_DATA,
  output logic [CSR_AW-1:0] WB_CSR_ADDR,
  output logic              WB_ST_CSR,
  output logic [XLEN-1:0]   WB_BR_JMP_TARGET,
  output logic              WB_PC_MUX_OUT,
  output logic              WB_FLUSH,
  output logic              WB_STALL,
  output logic [XLEN-1:0]   WB_CAUSE,
  output logic              WB_CS
);

  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
`ifdef WB_TVAL_EN
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_EPC,
    S_CAUSE,
    S_TVAL,
    S_REDIR
  } state_t;

  state_t            state;
  logic              busy;
  logic [XLEN-1:0]   trap_tgt_q;
`ifdef WB_TVAL_EN
  logic [XLEN-1:0]   tval_q;
  logic [XLEN-1:0]   tval_c;
`endif

  // Only the opcode, funct3 and CSR address fields of the IR are decoded here.
  logic unused_ir;
  assign unused_ir = ^{WB_IR[19:15], WB_IR[11:7]};

  assign WB_FLUSH = busy;
  assign WB_STALL = busy;
  assign WB_CS    = busy;

  // Trap detection and priority. The first true condition wins.
  logic            trap_hit;
  logic            is_irq;
  logic [3:0]      code;
  logic [XLEN-1:0] cause_c;
  logic [XLEN-1:0] tgt_c;

  always_comb begin
    trap_hit = 1'b1;
    is_irq   = 1'b0;
    code     = 4'd0;
`ifdef WB_TVAL_EN
    tval_c   = '0;
`endif
    if (IRQ_EN && EXTERNAL) begin
      is_irq = 1'b1;
      code   = 4'd11;
    end else if (IRQ_EN && TIMER) begin
      is_irq = 1'b1;
      code   = 4'd7;
    end else if (F_IAF) begin
      code = 4'd1;
`ifdef WB_TVAL_EN
      tval_c = WB_PC;
`endif
    end else if (F_II) begin
      code = 4'd2;
`ifdef WB_TVAL_EN
      tval_c = XLEN'(WB_IR);
`endif
    end else if (F_IAM) begin
      code = 4'd0;
`ifdef WB_TVAL_EN
      tval_c = WB_PC;
`endif
    end else if (WB_ECALL) begin
      code = PRIVILEGE ? 4'd11 : 4'd8;
    end else if (MEM_SAM) begin
      code = 4'd6;
`ifdef WB_TVAL_EN
      tval_c = WB_ALU_RESULT;
`endif
    end else if (MEM_LAM) begin
      code = 4'd4;
`ifdef WB_TVAL_EN
      tval_c = WB_ALU_RESULT;
`endif
    end else if (MEM_SAF) begin
      code = 4'd7;
`ifdef WB_TVAL_EN
      tval_c = WB_ALU_RESULT;
`endif
    end else if (MEM_LAF) begin
      code = 4'd5;
`ifdef WB_TVAL_EN
      tval_c = WB_ALU_RESULT;
`endif
    end else begin
      trap_hit = 1'b0;
    end

    cause_c            = '0;
    cause_c[XLEN-1]    = is_irq;
    cause_c[3:0]       = code;

    // Vectored mode applies to interrupts only. Exceptions always use the base address.
    tgt_c = {MTVEC[XLEN-1:2], 2'b00};
    if (VECTORED && (MTVEC[1:0] == 2'b01) && is_irq)
      tgt_c = tgt_c + XLEN'({code, 2'b00});
  end

  // Writeback source select by opcode
  logic            wb_ld;
  logic            wb_csr;
  logic [XLEN-1:0] wb_data;

  always_comb begin
    wb_ld   = 1'b0;
    wb_csr  = 1'b0;
    wb_data = WB_ALU_RESULT;
    casez (WB_IR[6:0])
      7'b0000011: begin
        wb_ld   = 1'b1;
        wb_data = WB_MEM_RESULT;
      end
      7'b0?10011, 7'b0?11011, 7'b0110111, 7'b0010111: begin
        wb_ld = 1'b1;
      end
      7'b110?111: begin
        wb_ld   = 1'b1;
        wb_data = WB_NPC;
      end
      7'b1110011: begin
        if (WB_IR[14:12] != 3'b000) begin
          wb_ld   = 1'b1;
          wb_csr  = 1'b1;
          wb_data = WB_RFD;
        end
      end
      default: begin
        wb_ld = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state            <= S_IDLE;
      busy             <= 1'b0;
      trap_tgt_q       <= '0;
`ifdef WB_TVAL_EN
      tval_q           <= '0;
`endif
      WB_RF_DATA       <= '0;
      WB_LD_REG        <= 1'b0;
      WB_DRID_OUT      <= '0;
      WB_CSR_DATA      <= '0;
      WB_CSR_ADDR      <= '0;
      WB_ST_CSR        <= 1'b0;
      WB_BR_JMP_TARGET <= '0;
      WB_PC_MUX_OUT    <= 1'b0;
      WB_CAUSE         <= '0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      WB_LD_REG     <= 1'b0;
      WB_ST_CSR     <= 1'b0;
      WB_PC_MUX_OUT <= 1'b0;

      case (state)
        S_IDLE: begin
          if (WB_V) begin
            if (trap_hit) begin
              state       <= S_EPC;
              busy        <= 1'b1;
              trap_tgt_q  <= tgt_c;
`ifdef WB_TVAL_EN
              tval_q      <= tval_c;
`endif
              WB_CAUSE    <= cause_c;
              WB_ST_CSR   <= 1'b1;
              WB_CSR_ADDR <= CSR_AW'(ADDR_MEPC);
              WB_CSR_DATA <= WB_PC;
            end else begin
              WB_LD_REG        <= wb_ld && (WB_DRID != 5'd0);
              WB_DRID_OUT      <= WB_DRID;
              WB_RF_DATA       <= wb_data;
              WB_PC_MUX_OUT    <= WB_PC_MUX;
              WB_BR_JMP_TARGET <= WB_ALU_RESULT;
              if (wb_csr) begin
                WB_ST_CSR   <= 1'b1;
                WB_CSR_ADDR <= CSR_AW'(WB_IR[31:20]);
                WB_CSR_DATA <= WB_CSRFD;
              end
            end
          end
        end

        S_EPC: begin
          state       <= S_CAUSE;
          WB_ST_CSR   <= 1'b1;
          WB_CSR_ADDR <= CSR_AW'(ADDR_MCAUSE);
          WB_CSR_DATA <= WB_CAUSE;
        end

        S_CAUSE: begin
`ifdef WB_TVAL_EN
          state       <= S_TVAL;
          WB_ST_CSR   <= 1'b1;
          WB_CSR_ADDR <= CSR_AW'(ADDR_MTVAL);
          WB_CSR_DATA <= tval_q;
`else
          state            <= S_REDIR;
          WB_PC_MUX_OUT    <= 1'b1;
          WB_BR_JMP_TARGET <= trap_tgt_q;
`endif
        end

        S_TVAL: begin
          state            <= S_REDIR;
          WB_PC_MUX_OUT    <= 1'b1;
          WB_BR_JMP_TARGET <= trap_tgt_q;
        end

        S_REDIR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trap_stage.sv
module tb_wb_trap_stage;

  localparam int XLEN   = 64;
  localparam int CSR_AW = 12;
  localparam bit VEC    = 1'b1;
`ifdef WB_TVAL_EN
  localparam bit TVAL_ON = 1'b1;
`else
  localparam bit TVAL_ON = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              WB_V;
  logic [XLEN-1:0]   WB_PC, WB_NPC, WB_MEM_RESULT, WB_ALU_RESULT, WB_RFD, WB_CSRFD, MTVEC;
  logic [31:0]       WB_IR;
  logic [4:0]        WB_DRID;
  logic              WB_PC_MUX, WB_ECALL, F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;
  logic              TIMER, EXTERNAL, IRQ_EN, PRIVILEGE;
  logic [XLEN-1:0]   WB_RF_DATA, WB_CSR_DATA, WB_BR_JMP_TARGET, WB_CAUSE;
  logic              WB_LD_REG, WB_ST_CSR, WB_PC_MUX_OUT, WB_FLUSH, WB_STALL, WB_CS;
  logic [4:0]        WB_DRID_OUT;
  logic [CSR_AW-1:0] WB_CSR_ADDR;

  wb_trap_stage #(.XLEN(XLEN), .CSR_AW(CSR_AW), .VECTORED(VEC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .WB_V(WB_V), .WB_PC(WB_PC), .WB_NPC(WB_NPC),
    .WB_IR(WB_IR), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_ALU_RESULT(WB_ALU_RESULT),
    .WB_RFD(WB_RFD), .WB_CSRFD(WB_CSRFD), .WB_DRID(WB_DRID), .WB_PC_MUX(WB_PC_MUX),
    .WB_ECALL(WB_ECALL), .F_IAM(F_IAM), .F_IAF(F_IAF), .F_II(F_II),
    .MEM_LAM(MEM_LAM), .MEM_LAF(MEM_LAF), .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF),
    .TIMER(TIMER), .EXTERNAL(EXTERNAL), .IRQ_EN(IRQ_EN), .PRIVILEGE(PRIVILEGE),
    .MTVEC(MTVEC), .WB_RF_DATA(WB_RF_DATA), .WB_LD_REG(WB_LD_REG),
    .WB_DRID_OUT(WB_DRID_OUT), .WB_CSR_DATA(WB_CSR_DATA), .WB_CSR_ADDR(WB_CSR_ADDR),
    .WB_ST_CSR(WB_ST_CSR), .WB_BR_JMP_TARGET(WB_BR_JMP_TARGET),
    .WB_PC_MUX_OUT(WB_PC_MUX_OUT), .WB_FLUSH(WB_FLUSH), .WB_STALL(WB_STALL),
    .WB_CAUSE(WB_CAUSE), .WB_CS(WB_CS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [63:0] pc, npc, mem, alu, rfd, csrfd, mtvec;
    logic [31:0] ir;
    logic [4:0]  drid;
    logic        pcmux, ecall, iam, iaf, ii, lam, laf, sam, saf;
    logic        timer, ext, irq_en, priv;
  } stim_t;

  typedef struct {
    logic        ld;
    logic [4:0]  drid;
    logic [63:0] rf;
    logic        st;
    logic [11:0] addr;
    logic [63:0] data;
    logic        pcmux;
    logic [63:0] tgt;
    logic        busy;
    logic [63:0] cause;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] last_cause = 64'd0;
  logic [63:0] seen_tgt   = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic stim_t zero_stim();
    stim_t s;
    s.v = 1'b0; s.pc = '0; s.npc = '0; s.mem = '0; s.alu = '0; s.rfd = '0;
    s.csrfd = '0; s.mtvec = '0; s.ir = 32'h0000_0013; s.drid = '0;
    s.pcmux = 1'b0; s.ecall = 1'b0; s.iam = 1'b0; s.iaf = 1'b0; s.ii = 1'b0;
    s.lam = 1'b0; s.laf = 1'b0; s.sam = 1'b0; s.saf = 1'b0;
    s.timer = 1'b0; s.ext = 1'b0; s.irq_en = 1'b0; s.priv = 1'b0;
    return s;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic stim_t rand_stim(input bit force_v);
    stim_t      s;
    logic [6:0] ops [13];
    bit         trapy;
    ops = '{7'h03, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h37, 7'h17,
            7'h6f, 7'h67, 7'h73, 7'h23, 7'h63, 7'h0f};
    s       = zero_stim();
    s.v     = force_v || ($urandom_range(0, 5) != 0);
    s.pc    = r64() & ~64'h3;
    s.npc   = s.pc + 64'd4;
    s.mem   = r64();
    s.alu   = r64();
    s.rfd   = r64();
    s.csrfd = r64();
    s.ir    = $urandom;
    s.ir[6:0] = ops[$urandom_range(0, 12)];
    s.drid  = 5'($urandom_range(0, 31));
    s.pcmux = 1'($urandom_range(0, 1));
    trapy   = ($urandom_range(0, 3) == 0);
    s.ecall = trapy && ($urandom_range(0, 2) == 0);
    s.iam   = trapy && ($urandom_range(0, 2) == 0);
    s.iaf   = trapy && ($urandom_range(0, 2) == 0);
    s.ii    = trapy && ($urandom_range(0, 2) == 0);
    s.lam   = trapy && ($urandom_range(0, 2) == 0);
    s.laf   = trapy && ($urandom_range(0, 2) == 0);
    s.sam   = trapy && ($urandom_range(0, 2) == 0);
    s.saf   = trapy && ($urandom_range(0, 2) == 0);
    s.timer = ($urandom_range(0, 5) == 0);
    s.ext   = ($urandom_range(0, 7) == 0);
    s.irq_en = 1'($urandom_range(0, 1));
    s.priv  = 1'($urandom_range(0, 1));
    s.mtvec = (r64() & ~64'h3) | 64'($urandom_range(0, 2));
    return s;
  endfunction

  task automatic apply(input stim_t s);
    WB_V = s.v; WB_PC = s.pc; WB_NPC = s.npc; WB_IR = s.ir;
    WB_MEM_RESULT = s.mem; WB_ALU_RESULT = s.alu; WB_RFD = s.rfd; WB_CSRFD = s.csrfd;
    WB_DRID = s.drid; WB_PC_MUX = s.pcmux; WB_ECALL = s.ecall;
    F_IAM = s.iam; F_IAF = s.iaf; F_II = s.ii;
    MEM_LAM = s.lam; MEM_LAF = s.laf; MEM_SAM = s.sam; MEM_SAF = s.saf;
    TIMER = s.timer; EXTERNAL = s.ext; IRQ_EN = s.irq_en; PRIVILEGE = s.priv;
    MTVEC = s.mtvec;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.ld = 1'b0; e.drid = '0; e.rf = '0; e.st = 1'b0; e.addr = '0; e.data = '0;
    e.pcmux = 1'b0; e.tgt = '0; e.busy = 1'b0; e.cause = last_cause;
    return e;
  endfunction

  // Trap model: walk the priority list from highest to lowest. The first raised source wins.
  task automatic model_trap(input stim_t s, output bit hit, output logic [63:0] cause,
                            output logic [63:0] tval, output logic [63:0] tgt);
    bit          raised [10];
    int          codes  [10];
    logic [63:0] tvals  [10];
    bit          intr;
    raised = '{s.irq_en && s.ext, s.irq_en && s.timer, s.iaf, s.ii, s.iam,
               s.ecall, s.sam, s.lam, s.saf, s.laf};
    codes  = '{11, 7, 1, 2, 0, (s.priv ? 11 : 8), 6, 4, 7, 5};
    tvals  = '{64'd0, 64'd0, s.pc, {32'd0, s.ir}, s.pc, 64'd0, s.alu, s.alu, s.alu, s.alu};
    hit = 1'b0; cause = '0; tval = '0; intr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (raised[i] && !hit) begin
        hit   = 1'b1;
        intr  = (i < 2);
        cause = (intr ? 64'h8000_0000_0000_0000 : 64'd0) + 64'(codes[i]);
        tval  = tvals[i];
      end
    end
    tgt = s.mtvec - (s.mtvec % 64'd4);
    if (VEC && (s.mtvec % 64'd4 == 64'd1) && intr)
      tgt = tgt + 64'd4 * (cause % 64'd64);
  endtask

  function automatic exp_t model_retire(input stim_t s);
    exp_t       e;
    logic [6:0] op;
    bit         writes;
    e      = idle_exp();
    op     = s.ir[6:0];
    writes = 1'b1;
    if (op == 7'h03)
      e.rf = s.mem;
    else if (op inside {7'h13, 7'h33, 7'h1b, 7'h3b, 7'h37, 7'h17})
      e.rf = s.alu;
    else if (op inside {7'h6f, 7'h67})
      e.rf = s.npc;
    else if (op == 7'h73 && s.ir[14:12] != 3'd0) begin
      e.rf   = s.rfd;
      e.st   = 1'b1;
      e.addr = s.ir[31:20];
      e.data = s.csrfd;
    end else
      writes = 1'b0;
    e.ld    = writes && (s.drid != 5'd0);
    e.drid  = s.drid;
    e.pcmux = s.pcmux;
    e.tgt   = s.alu;
    return e;
  endfunction

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".ld"}, 64'(WB_LD_REG), 64'(e.ld));
    if (e.ld) begin
      chk({tag, ".drid"}, 64'(WB_DRID_OUT), 64'(e.drid));
      chk({tag, ".rf"}, WB_RF_DATA, e.rf);
    end
    chk({tag, ".st"}, 64'(WB_ST_CSR), 64'(e.st));
    if (e.st) begin
      chk({tag, ".addr"}, 64'(WB_CSR_ADDR), 64'(e.addr));
      chk({tag, ".data"}, WB_CSR_DATA, e.data);
    end
    chk({tag, ".pcmux"}, 64'(WB_PC_MUX_OUT), 64'(e.pcmux));
    if (e.pcmux) chk({tag, ".tgt"}, WB_BR_JMP_TARGET, e.tgt);
    chk({tag, ".flush"}, 64'(WB_FLUSH), 64'(e.busy));
    chk({tag, ".stall"}, 64'(WB_STALL), 64'(e.busy));
    chk({tag, ".cs"}, 64'(WB_CS), 64'(e.busy));
    chk({tag, ".cause"}, WB_CAUSE, e.cause);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".rf"}, WB_RF_DATA, 64'd0);
    chk({tag, ".ld"}, 64'(WB_LD_REG), 64'd0);
    chk({tag, ".drid"}, 64'(WB_DRID_OUT), 64'd0);
    chk({tag, ".data"}, WB_CSR_DATA, 64'd0);
    chk({tag, ".addr"}, 64'(WB_CSR_ADDR), 64'd0);
    chk({tag, ".st"}, 64'(WB_ST_CSR), 64'd0);
    chk({tag, ".tgt"}, WB_BR_JMP_TARGET, 64'd0);
    chk({tag, ".pcmux"}, 64'(WB_PC_MUX_OUT), 64'd0);
    chk({tag, ".flush"}, 64'(WB_FLUSH), 64'd0);
    chk({tag, ".stall"}, 64'(WB_STALL), 64'd0);
    chk({tag, ".cause"}, WB_CAUSE, 64'd0);
    chk({tag, ".cs"}, 64'(WB_CS), 64'd0);
  endtask

  // One instruction slot. A trap is followed through its whole sequence while unrelated random stimulus is applied, and that stimulus must be ignored.
  task automatic run_one(input stim_t s, input string tag);
    bit          hit;
    logic [63:0] c, tv, tg;
    exp_t        e;
    apply(s);
    step();
    e = idle_exp();
    if (!s.v) begin
      chk_out(tag, e);
      return;
    end
    model_trap(s, hit, c, tv, tg);
    if (!hit) begin
      chk_out(tag, model_retire(s));
      return;
    end
    last_cause = c;
    e.cause = c; e.busy = 1'b1; e.st = 1'b1;
    e.addr = 12'h341; e.data = s.pc;
    chk_out({tag, ".epc"}, e);
    apply(rand_stim(1'b1)); step();
    e.addr = 12'h342; e.data = c;
    chk_out({tag, ".mcause"}, e);
    if (TVAL_ON) begin
      apply(rand_stim(1'b1)); step();
      e.addr = 12'h343; e.data = tv;
      chk_out({tag, ".mtval"}, e);
    end
    apply(rand_stim(1'b1)); step();
    e.st = 1'b0; e.pcmux = 1'b1; e.tgt = tg;
    seen_tgt = WB_BR_JMP_TARGET;
    chk_out({tag, ".redir"}, e);
    apply(rand_stim(1'b1)); step();
    chk_out({tag, ".after"}, idle_exp());
  endtask

  initial begin
    stim_t s;
    exp_t  e;

    apply(zero_stim());
    #2;
    reset_check("reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    step();

    // ADDI x5, then an idle cycle
    s = zero_stim(); s.v = 1'b1; s.ir = 32'h0010_0293; s.drid = 5'd5; s.alu = 64'h1234;
    run_one(s, "addi");
    chk("addi.ld_k", 64'(WB_LD_REG), 64'd1);
    chk("addi.rf_k", WB_RF_DATA, 64'h1234);
    run_one(zero_stim(), "addi_idle");

    // LW to x0
    s = zero_stim(); s.v = 1'b1; s.ir = 32'h0000_2003; s.drid = 5'd0; s.mem = 64'hDEAD;
    run_one(s, "lw_x0");
    chk("lw_x0.ld_k", 64'(WB_LD_REG), 64'd0);

    // CSRRW x3, 0x300
    s = zero_stim(); s.v = 1'b1; s.ir = {12'h300, 5'd1, 3'b001, 5'd3, 7'h73};
    s.drid = 5'd3; s.rfd = 64'h8; s.csrfd = 64'h88;
    run_one(s, "csrrw");
    chk("csrrw.addr_k", 64'(WB_CSR_ADDR), 64'h300);
    chk("csrrw.data_k", WB_CSR_DATA, 64'h88);

    // ECALL from U-mode
    s = zero_stim(); s.v = 1'b1; s.ir = 32'h0000_0073; s.ecall = 1'b1;
    s.pc = 64'h100; s.mtvec = 64'h8000;
    run_one(s, "ecall_u");
    chk("ecall_u.cause_k", WB_CAUSE, 64'd8);
    chk("ecall_u.tgt_k", seen_tgt, 64'h8000);

    // Timer interrupt beats a load access fault, vectored
    s = zero_stim(); s.v = 1'b1; s.ir = 32'h0000_2003; s.drid = 5'd7;
    s.timer = 1'b1; s.laf = 1'b1; s.irq_en = 1'b1; s.mtvec = 64'h8001; s.pc = 64'h200;
    run_one(s, "tmr_laf");
    chk("tmr_laf.cause_k", WB_CAUSE, 64'h8000_0000_0000_0007);
    chk("tmr_laf.tgt_k", seen_tgt, 64'h801C);
    s.irq_en = 1'b0;
    run_one(s, "laf_only");
    chk("laf_only.cause_k", WB_CAUSE, 64'd5);
    chk("laf_only.tgt_k", seen_tgt, 64'h8000);

    // Reset while the mcause write is presented
    s = zero_stim(); s.v = 1'b1; s.ecall = 1'b1; s.priv = 1'b1;
    s.pc = 64'h300; s.mtvec = 64'h9000;
    apply(s); step();
    apply(rand_stim(1'b1)); step();
    chk("rst_mid.pre_st", 64'(WB_ST_CSR), 64'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    reset_check("rst_mid");
    last_cause = 64'd0;
    apply(zero_stim());
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("rst_after", idle_exp());
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = rand_stim(1'b0);
      run_one(s, "rnd");
    end

    e = idle_exp();
    apply(zero_stim());
    step();
    chk_out("final", e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trap_stage.md
Name: wb_trap_stage

Overview:
- Parametrised successor writeback stage for the RISC-V core.
- Selects and registers register-file and CSR write data per instruction class.
- Prioritises synchronous exceptions and asynchronous interrupts.
- On a trap, runs a multi-cycle trap-entry sequence through the single CSR write port: mepc, mcause, optional mtval, then redirects fetch to the trap vector while stalling and flushing the pipeline.

Parameters:
XLEN, 64, datapath/register width (32 or 64)
CSR_AW, 12, CSR address width
VECTORED, 1, 1 = honour MTVEC[1:0]==01 vectored mode for interrupts; 0 = always direct

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
WB_V  in  1  WB-stage instruction valid
WB_PC  in  XLEN  PC of WB instruction
WB_NPC  in  XLEN  PC+4 of WB instruction
WB_IR  in  32  instruction
WB_MEM_RESULT  in  XLEN  load data
WB_ALU_RESULT  in  XLEN  ALU result / branch target / mem address
WB_RFD  in  XLEN  old CSR value for rd (CSR instrs)
WB_CSRFD  in  XLEN  new CSR value (CSR instrs)
WB_DRID  in  5  destination register
WB_PC_MUX  in  1  taken branch/jump
WB_ECALL, F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF  in  1 each  exception flags for WB instruction
TIMER, EXTERNAL  in  1 each  interrupt requests (level)
IRQ_EN  in  1  global interrupt enable (mstatus.MIE)
PRIVILEGE  in  1  1 = M-mode, 0 = U-mode
MTVEC  in  XLEN  trap vector CSR
WB_RF_DATA  out  XLEN  register write data
WB_LD_REG  out  1  register write enable
WB_DRID_OUT  out  5  register write index
WB_CSR_DATA  out  XLEN  CSR write data
WB_CSR_ADDR  out  CSR_AW  CSR write address
WB_ST_CSR  out  1  CSR write enable
WB_BR_JMP_TARGET  out  XLEN  fetch redirect target
WB_PC_MUX_OUT  out  1  fetch redirect enable
WB_FLUSH  out  1  kill all younger stages
WB_STALL  out  1  freeze upstream stages
WB_CAUSE  out  XLEN  latched trap cause
WB_CS  out  1  context switch in progress

Behaviour:
- All outputs registered; reset (RESET_N low, async) clears every output to 0 and FSM to IDLE. Normal writeback latency 1 cycle.
- Writeback select when WB_V and no trap: opcode 0000011 -> MEM_RESULT; 0x10011, 0x11011, 0110111, 0010111 -> ALU_RESULT; 1101111/1100111 -> NPC; 1110011 with funct3!=0 -> RF=RFD, CSR_DATA=CSRFD, CSR_ADDR=IR[31:20], ST_CSR=1; stores/branches -> LD_REG=0. LD_REG forced 0 when WB_DRID==0. PC_MUX_OUT=WB_PC_MUX, target=ALU_RESULT.
- Enable strobes (LD_REG, ST_CSR, PC_MUX_OUT) are single-cycle; deasserted when WB_V=0.
- Trap detect (WB_V=1 only): interrupts first if IRQ_EN: EXTERNAL (11) > TIMER (7), cause MSB=1. Then exceptions: F_IAF(1) > F_II(2) > F_IAM(0) > ECALL(8 if U, 11 if M) > MEM_SAM(6) > MEM_LAM(4) > MEM_SAF(7) > MEM_LAF(5).
- Trapping instruction does not retire: no RF, no CSR-instr write, no branch redirect.
- FSM: IDLE -> EPC (ST_CSR, addr 0x341, data WB_PC) -> CAUSE (0x342, cause) -> [TVAL] -> REDIR -> IDLE.
- WB_CS, WB_STALL and WB_FLUSH are high from EPC through REDIR.
- In REDIR: PC_MUX_OUT=1. Target = {MTVEC[XLEN-1:2],2'b00}, plus 4*cause[5:0] if VECTORED, MTVEC[1:0]==01 and interrupt.
- WB_CAUSE holds the latched cause until the next trap.
- Inputs are ignored while not IDLE; WB PC/cause/tval are latched at detection.
- New interrupts during the sequence are not taken until IDLE.
- Reset mid-sequence aborts it with no further CSR writes.

Optional Feature:
- Macro WB_TVAL_EN.
- Defined: TVAL state inserted after CAUSE, writing 0x343 with tval:
  - WB_ALU_RESULT for LAM/LAF/SAM/SAF;
  - WB_PC for IAM/IAF;
  - zero-extended WB_IR for II;
  - 0 otherwise.
- Undefined: no TVAL state; sequence is 3 cycles and mtval is never written.

Test Plan:
- ADDI rd=5, ALU_RESULT=0x1234, WB_V=1 -> next cycle LD_REG=1, DRID_OUT=5, RF_DATA=0x1234; following cycle LD_REG=0.
- LW rd=0, MEM_RESULT=0xDEAD -> LD_REG=0.
- CSRRW rd=3, IR[31:20]=0x300, RFD=0x8, CSRFD=0x88 -> RF_DATA=0x8, LD_REG=1, CSR_ADDR=0x300, CSR_DATA=0x88, ST_CSR=1.
- ECALL in U-mode, WB_PC=0x100, MTVEC=0x8000 -> CSR writes 0x341<=0x100, then 0x342<=8, then redirect to 0x8000. STALL/FLUSH/CS high for 3 cycles (4 with WB_TVAL_EN, mtval=0).
- TIMER=1 and MEM_LAF=1 simultaneously, IRQ_EN=1, MTVEC=0x8001 -> cause=0x8000_0000_0000_0007, target=0x801C. With IRQ_EN=0 -> cause=5, target=0x8000.
- RESET_N low during CAUSE state -> all outputs 0 immediately; no redirect after release.
